// File: rtl/peripheral_dbg_pu_riscv_pkg.sv
// Shared definitions for the debug-unit CPU port arbiter: FSM states and default sizing.
package peripheral_dbg_pu_riscv_pkg;

    localparam int DBG_NUM_CORES = 32;
    localparam int DBG_TIMEOUT   = 255;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } dbg_arb_state_e;

    // Index width that never collapses to zero bits for single-entry sets.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/peripheral_dbg_pu_riscv_rr_arbiter.sv
// Round-robin selector: picks the first requester above the last grantee, wrapping to bit 0.
module peripheral_dbg_pu_riscv_rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] last_gnt,
    output logic [NUM_REQ-1:0] gnt
);

    logic [NUM_REQ-1:0] hi_mask;
    logic [NUM_REQ-1:0] masked;

    // An all-zero last_gnt yields an empty mask, so priority falls back to bit 0.
    always_comb begin
        hi_mask = ~((last_gnt - NUM_REQ'(1)) | last_gnt);
        masked  = req & hi_mask;
        if (masked != '0) begin
            gnt = masked & (~masked + NUM_REQ'(1));
        end else begin
            gnt = req & (~req + NUM_REQ'(1));
        end
    end

endmodule

// File: rtl/peripheral_dbg_pu_riscv_cpu_arbiter.sv
// Shares one CPU debug port among several requesters: round-robin grant, single access, timed response.
module peripheral_dbg_pu_riscv_cpu_arbiter
    import peripheral_dbg_pu_riscv_pkg::*;
#(
    parameter int  NUM_CORES      = DBG_NUM_CORES,
    parameter int  NUM_REQ        = 2,
    parameter int  CPU_ADDR_WIDTH = 32,
    parameter int  CPU_DATA_WIDTH = 32,
    parameter int  TIMEOUT        = DBG_TIMEOUT,
    localparam int CW             = idx_width(NUM_CORES)
) (
    input  logic                                     cpu_clk_i,
    input  logic                                     cpu_rstn_i,
    input  logic [NUM_REQ-1:0]                       req_i,
    input  logic [NUM_REQ-1:0][CW-1:0]               req_core_i,
    input  logic [NUM_REQ-1:0][CPU_ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [NUM_REQ-1:0][CPU_DATA_WIDTH-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]                       req_we_i,
    output logic [NUM_REQ-1:0]                       gnt_o,
    output logic [NUM_REQ-1:0]                       rsp_valid_o,
    output logic [CPU_DATA_WIDTH-1:0]                rsp_data_o,
    output logic                                     rsp_err_o,
    output logic [CPU_ADDR_WIDTH-1:0]                cpu_addr_o,
    output logic [CPU_DATA_WIDTH-1:0]                cpu_data_o,
    output logic [NUM_CORES-1:0]                     cpu_stb_o,
    output logic [NUM_CORES-1:0]                     cpu_we_o,
    input  logic [NUM_CORES-1:0][CPU_DATA_WIDTH-1:0] cpu_data_i,
    input  logic [NUM_CORES-1:0]                     cpu_ack_i
);

    localparam int TW = idx_width(TIMEOUT + 1);

    dbg_arb_state_e              state_q;
    logic [NUM_REQ-1:0]          last_gnt_q;
    logic [NUM_REQ-1:0]          owner_q;
    logic [NUM_REQ-1:0]          win;
    logic [TW-1:0]               cnt_q;
    logic                        we_q;
    logic [CW-1:0]               sel_core;
    logic [CPU_ADDR_WIDTH-1:0]   sel_addr;
    logic [CPU_DATA_WIDTH-1:0]   sel_data;
    logic                        sel_we;
    logic [NUM_CORES-1:0]        sel_dec;
    logic [NUM_CORES-1:0]        ack_hit;
    logic [CPU_DATA_WIDTH-1:0]   ack_data;
    logic                        timeout_hit;

    peripheral_dbg_pu_riscv_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req      (req_i),
        .last_gnt (last_gnt_q),
        .gnt      (win)
    );

    always_comb begin
        sel_core = '0;
        sel_addr = '0;
        sel_data = '0;
        sel_we   = 1'b0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (win[r]) begin
                sel_core = req_core_i[r];
                sel_addr = req_addr_i[r];
                sel_data = req_data_i[r];
                sel_we   = req_we_i[r];
            end
        end
    end

    // Out-of-range core indices decode to no strobe at all; an empty strobe marks the access invalid.
    always_comb begin
        sel_dec = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            sel_dec[i] = (sel_core == CW'(i));
        end
    end

    // The live strobe doubles as the core select, so stray acks and acks outside ACCESS drop out here.
    always_comb begin
        ack_hit  = cpu_ack_i & cpu_stb_o;
        ack_data = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (ack_hit[i]) begin
                ack_data = cpu_data_i[i];
            end
        end
        timeout_hit = (int'(cnt_q) >= TIMEOUT - 1);
    end

    always_ff @(posedge cpu_clk_i or negedge cpu_rstn_i) begin
        if (!cpu_rstn_i) begin
            state_q     <= ST_IDLE;
            last_gnt_q  <= '0;
            owner_q     <= '0;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            gnt_o       <= '0;
            rsp_valid_o <= '0;
            rsp_data_o  <= '0;
            rsp_err_o   <= 1'b0;
            cpu_addr_o  <= '0;
            cpu_data_o  <= '0;
            cpu_stb_o   <= '0;
            cpu_we_o    <= '0;
        end else begin
            gnt_o       <= '0;
            rsp_valid_o <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (|req_i) begin
                        state_q    <= ST_ACCESS;
                        gnt_o      <= win;
                        owner_q    <= win;
                        last_gnt_q <= win;
                        cpu_addr_o <= sel_addr;
                        cpu_data_o <= sel_data;
                        we_q       <= sel_we;
                        cpu_stb_o  <= sel_dec;
                        cpu_we_o   <= sel_dec & {NUM_CORES{sel_we}};
                        cnt_q      <= '0;
                    end
                end
                ST_ACCESS: begin
                    if (cpu_stb_o == '0) begin
                        state_q     <= ST_RESP;
                        rsp_valid_o <= owner_q;
                        rsp_err_o   <= 1'b1;
                        rsp_data_o  <= '0;
                    end else if (|ack_hit) begin
                        state_q     <= ST_RESP;
                        rsp_valid_o <= owner_q;
                        rsp_err_o   <= 1'b0;
                        rsp_data_o  <= we_q ? '0 : ack_data;
                        cpu_stb_o   <= '0;
                        cpu_we_o    <= '0;
                    end else if (timeout_hit) begin
                        state_q     <= ST_RESP;
                        rsp_valid_o <= owner_q;
                        rsp_err_o   <= 1'b1;
                        rsp_data_o  <= '0;
                        cpu_stb_o   <= '0;
                        cpu_we_o    <= '0;
                    end else if (int'(cnt_q) < TIMEOUT) begin
                        cnt_q <= cnt_q + TW'(1);
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_peripheral_dbg_pu_riscv_cpu_arbiter.sv
// Directed scoreboard bench for the debug CPU port arbiter (30 cores, 2 requesters).
module tb_peripheral_dbg_pu_riscv_cpu_arbiter;

    localparam int NC = 30;
    localparam int NR = 2;
    localparam int CW = 5;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 255;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NR-1:0]          req;
    logic [NR-1:0][CW-1:0]  req_core;
    logic [NR-1:0][AW-1:0]  req_addr;
    logic [NR-1:0][DW-1:0]  req_data;
    logic [NR-1:0]          req_we;
    logic [NR-1:0]          gnt;
    logic [NR-1:0]          rsp_valid;
    logic [DW-1:0]          rsp_data;
    logic                   rsp_err;
    logic [AW-1:0]          cpu_addr;
    logic [DW-1:0]          cpu_wdata;
    logic [NC-1:0]          stb;
    logic [NC-1:0]          we;
    logic [NC-1:0][DW-1:0]  cpu_rdata;
    logic [NC-1:0]          ack;

    typedef struct {
        logic [NR-1:0] who;
        logic [DW-1:0] data;
        logic          err;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    peripheral_dbg_pu_riscv_cpu_arbiter #(
        .NUM_CORES      (NC),
        .NUM_REQ        (NR),
        .CPU_ADDR_WIDTH (AW),
        .CPU_DATA_WIDTH (DW),
        .TIMEOUT        (TO)
    ) dut (
        .cpu_clk_i   (clk),
        .cpu_rstn_i  (rst_n),
        .req_i       (req),
        .req_core_i  (req_core),
        .req_addr_i  (req_addr),
        .req_data_i  (req_data),
        .req_we_i    (req_we),
        .gnt_o       (gnt),
        .rsp_valid_o (rsp_valid),
        .rsp_data_o  (rsp_data),
        .rsp_err_o   (rsp_err),
        .cpu_addr_o  (cpu_addr),
        .cpu_data_o  (cpu_wdata),
        .cpu_stb_o   (stb),
        .cpu_we_o    (we),
        .cpu_data_i  (cpu_rdata),
        .cpu_ack_i   (ack)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid !== '0) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: rsp_valid_o=0x%0h, expected no response", rsp_valid);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_owner", 64'(rsp_valid), 64'(e.who));
                    check("sb_data", 64'(rsp_data), 64'(e.data));
                    check("sb_err", 64'(rsp_err), 64'(e.err));
                end
            end
        end
    endtask

    // One complete transaction; ack_after = ACCESS cycle carrying the ack (0 = never), stray = extra acked core in cycle 1.
    task automatic access(input int r, input int core, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic wr, input int ack_after, input int stray, input logic [DW-1:0] rdata);
        rsp_t          e;
        int            cnt;
        int            exp_cnt;
        logic [NR-1:0] who;
        logic [NC-1:0] bit_c;
        who   = NR'(1) << r;
        bit_c = NC'(1) << core;
        req_core[r] = CW'(core);
        req_addr[r] = addr;
        req_data[r] = wdata;
        req_we[r]   = wr;
        req[r]      = 1'b1;
        if (ack_after > 0) cpu_rdata[core] = rdata;
        e.who  = who;
        e.data = (wr || ack_after == 0) ? '0 : rdata;
        e.err  = (ack_after == 0);
        exp_q.push_back(e);
        tick();
        req[r] = 1'b0;
        check("gnt", 64'(gnt), 64'(who));
        check("stb_onehot", 64'(stb), 64'(bit_c));
        check("we", 64'(we), wr ? 64'(bit_c) : 64'(0));
        check("cpu_addr", 64'(cpu_addr), 64'(addr));
        check("cpu_wdata", 64'(cpu_wdata), 64'(wdata));
        exp_cnt = (ack_after > 0) ? ack_after : TO;
        cnt = 0;
        for (int c = 1; c <= 400; c++) begin
            if ((stb & bit_c) == '0) break;
            cnt++;
            if (c == 2) check("gnt_pulse", 64'(gnt), 64'(0));
            if (c == 1 && stray >= 0) ack = ack | (NC'(1) << stray);
            if (c == ack_after) ack = ack | bit_c;
            tick();
            ack = '0;
        end
        check("stb_cycles", 64'(cnt), 64'(exp_cnt));
        check("rsp_latency", 64'(rsp_valid), 64'(who));
        check("stb_dropped", 64'(stb), 64'(0));
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rsp_t          e;
        logic [NR-1:0] exp_who;
        int            w;
        req      = '0;
        req_core = '0;
        req_addr = '0;
        req_data = '0;
        req_we   = '0;
        ack      = '0;
        for (int i = 0; i < NC; i++) cpu_rdata[i] = 32'hC0DE_0000 | 32'(i);
        fork
            monitor();
        join_none

        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt", 64'(gnt), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_stb", 64'(stb), 64'(0));
        check("rst_we", 64'(we), 64'(0));
        check("rst_rsp_data", 64'(rsp_data), 64'(0));
        check("rst_rsp_err", 64'(rsp_err), 64'(0));
        rst_n = 1'b1;
        tick();

        access(0, 5, 32'h100, 32'h0, 1'b0, 3, -1, 32'hDEAD_BEEF);
        check("rsp_data_hold", 64'(rsp_data), 64'(32'hDEAD_BEEF));
        access(1, 3, 32'h300, 32'h55, 1'b1, 1, -1, 32'h1234_5678);
        access(0, 2, 32'h200, 32'hCAFE, 1'b1, 0, -1, 32'h0);
        check("timeout_err_hold", 64'(rsp_err), 64'(1));
        check("timeout_data_hold", 64'(rsp_data), 64'(0));
        access(1, 5, 32'h500, 32'h0, 1'b0, 3, 7, 32'hA5A5_0005);

        // Reset in the middle of an access from requester 0.
        req_core[0] = CW'(4);
        req_addr[0] = 32'h400;
        req_data[0] = 32'h77;
        req_we[0]   = 1'b0;
        req[0]      = 1'b1;
        tick();
        req[0] = 1'b0;
        check("abort_gnt", 64'(gnt), 64'(1));
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("abort_stb", 64'(stb), 64'(0));
        check("abort_we", 64'(we), 64'(0));
        check("abort_addr", 64'(cpu_addr), 64'(0));
        check("abort_wdata", 64'(cpu_wdata), 64'(0));
        check("abort_rsp_data", 64'(rsp_data), 64'(0));
        check("abort_rsp_valid", 64'(rsp_valid), 64'(0));
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Both requesters held: grants alternate starting from requester 0.
        req_core[0] = CW'(6);
        req_addr[0] = 32'h600;
        req_we[0]   = 1'b0;
        req_core[1] = CW'(8);
        req_addr[1] = 32'h800;
        req_we[1]   = 1'b0;
        cpu_rdata[6] = 32'h6666_0000;
        cpu_rdata[8] = 32'h8888_0000;
        req = 2'b11;
        for (int n = 0; n < 4; n++) begin
            exp_who = (n % 2 == 0) ? 2'b01 : 2'b10;
            w = 0;
            while (gnt == '0 && w < 10) begin
                tick();
                w++;
            end
            check("rr_gnt", 64'(gnt), 64'(exp_who));
            e.who  = exp_who;
            e.data = exp_who[0] ? 32'h6666_0000 : 32'h8888_0000;
            e.err  = 1'b0;
            exp_q.push_back(e);
            ack = exp_who[0] ? (NC'(1) << 6) : (NC'(1) << 8);
            tick();
            ack = '0;
            if (n == 3) req = '0;
        end
        tick();
        tick();

        // Core index beyond NUM_CORES: grant, no strobe, error response.
        req_core[1] = CW'(31);
        req_addr[1] = 32'hF00;
        req_we[1]   = 1'b0;
        req[1]      = 1'b1;
        e.who  = 2'b10;
        e.data = '0;
        e.err  = 1'b1;
        exp_q.push_back(e);
        tick();
        req[1] = 1'b0;
        check("inv_gnt", 64'(gnt), 64'(2'b10));
        check("inv_stb_c1", 64'(stb), 64'(0));
        tick();
        check("inv_stb_c2", 64'(stb), 64'(0));
        check("inv_err", 64'(rsp_err), 64'(1));
        check("inv_rsp_valid", 64'(rsp_valid), 64'(2'b10));

        repeat (3) tick();
        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
